qea_state_reader: RTL and testbench

//  Readback engine for the QEA state RAM port. After a run completes, it sweeps all
//  2**(qbit_num-PE_NUM_WIDTH) state-RAM words and unpacks each word into PE_NUM amplitudes.
//  It streams the amplitudes out in ascending basis-index order over a valid/ready interface.
//  It sits between QEA (state port) and the host/capture logic, the read-side counterpart of the state loader.

---
 rtl/qea_pkg.sv | 26 ++
 rtl/qea_word_unpacker.sv | 33 +++
 rtl/qea_state_reader.sv | 156 +++++++++++++++
 tb/tb_qea_state_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_pkg.sv
// Shared definitions for the QEA state-RAM readback path: default widths,
// the complex amplitude layout and the reader FSM state encoding.
package qea_pkg;

  localparam int QEA_PE_NUM_WIDTH     = 2;
  localparam int QEA_PE_NUM           = 1 << QEA_PE_NUM_WIDTH;
  localparam int QEA_DATA_WIDTH       = 32;
  localparam int QEA_STATE_DATA_WIDTH = 2 * QEA_DATA_WIDTH;
  localparam int QEA_STATE_ADDR_WIDTH = 16;
  localparam int QEA_MAX_QBIT_WIDTH   = 6;

  // One complex amplitude, real part in the upper half (Q2.30 each)
  typedef struct packed {
    logic [QEA_DATA_WIDTH-1:0] re;
    logic [QEA_DATA_WIDTH-1:0] im;
  } amp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

endpackage

// File: rtl/qea_word_unpacker.sv
// Holds one captured state-RAM word and selects a single amplitude lane from it.
// Lane 0 is the most significant slice of the word.
module qea_word_unpacker #(
  parameter int LANES  = 4,
  parameter int LANE_W = 2,
  parameter int SDW    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [LANES*SDW-1:0]   i_word,
  input  logic [LANE_W-1:0]      i_lane,
  output logic [SDW-1:0]         o_lane_data
);

  logic [LANES*SDW-1:0] word_q;
  logic [SDW-1:0]       lanes [LANES];

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (i_load) begin
      word_q <= i_word;
    end
  end

  for (genvar p = 0; p < LANES; p++) begin : g_lane
    assign lanes[p] = word_q[(LANES-p)*SDW-1 -: SDW];
  end

  assign o_lane_data = lanes[i_lane];

endmodule

// File: rtl/qea_state_reader.sv
// Sweeps the QEA state RAM after a run and streams every amplitude out in
// ascending basis-index order over a valid/ready interface.
//
//   state | meaning
//   IDLE  | waiting for i_start; out-of-range qubit count pulses o_err
//   REQ   | one-cycle state-RAM read of word addr
//   WAIT  | RD_LATENCY cycles for read data, then capture the word
//   SEND  | present lane by lane; next word or DONE after the last lane
//   DONE  | one-cycle o_done, back to IDLE
module qea_state_reader
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = QEA_PE_NUM_WIDTH,
  parameter int PE_NUM           = 1 << PE_NUM_WIDTH,
  parameter int DATA_WIDTH       = QEA_DATA_WIDTH,
  parameter int STATE_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH = QEA_STATE_ADDR_WIDTH,
  parameter int MAX_QBIT_WIDTH   = QEA_MAX_QBIT_WIDTH,
  parameter int RD_LATENCY       = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_err,
  output logic                                   o_state_ena,
  output logic                                   o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
  output logic                                   o_amp_valid,
  input  logic                                   i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]            o_amp_data,
  output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_idx,
  output logic                                   o_amp_last
);

  localparam int SAW = STATE_ADDR_WIDTH;
  localparam int PW  = PE_NUM_WIDTH;
  localparam int MQW = MAX_QBIT_WIDTH;
  localparam logic [MQW-1:0] Q_MAX    = MQW'(SAW + PW);
  localparam logic [MQW-1:0] Q_LANE   = MQW'(PW);
  localparam logic [1:0]     LAT_INIT = 2'(RD_LATENCY - 1);

  rd_state_e        state_q, state_d;
  logic [SAW-1:0]   addr_q, addr_d;
  logic [SAW-1:0]   last_addr_q, last_addr_d;
  logic [PW-1:0]    lane_q, lane_d;
  logic [PW-1:0]    last_lane_q, last_lane_d;
  logic [1:0]       lat_q, lat_d;
  logic             err_q, err_d;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      lane_q      <= '0;
      last_lane_q <= '0;
      lat_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      lane_q      <= lane_d;
      last_lane_q <= last_lane_d;
      lat_q       <= lat_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    lane_d      = lane_q;
    last_lane_d = last_lane_q;
    lat_d       = lat_q;
    err_d       = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_qbit_num > Q_MAX) begin
            err_d = 1'b1;
          end else begin
            addr_d = '0;
            lane_d = '0;
            // Last word is 2**(q-PW)-1; below one full word only lanes 0..2**q-1 exist
            if (i_qbit_num > Q_LANE) last_addr_d = {SAW{1'b1}} >> (Q_MAX - i_qbit_num);
            else                     last_addr_d = '0;
            if (i_qbit_num < Q_LANE) last_lane_d = {PW{1'b1}} >> (Q_LANE - i_qbit_num);
            else                     last_lane_d = '1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        lat_d   = LAT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_SEND: begin
        if (i_amp_ready) begin
          if (lane_q == last_lane_q) begin
            lane_d = '0;
            if (addr_q == last_addr_q) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + SAW'(1);
              state_d = ST_REQ;
            end
          end else begin
            lane_d = lane_q + PW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  qea_word_unpacker #(
    .LANES  (PE_NUM),
    .LANE_W (PW),
    .SDW    (STATE_DATA_WIDTH)
  ) u_unpacker (
    .clk         (clk),
    .rst         (rst),
    .i_load      (load),
    .i_word      (i_state_dout),
    .i_lane      (lane_q),
    .o_lane_data (o_amp_data)
  );

  assign o_busy        = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign o_done        = (state_q == ST_DONE);
  assign o_err         = err_q;
  assign o_state_ena   = (state_q == ST_REQ);
  assign o_state_wea   = 1'b0;
  assign o_state_addra = addr_q;
  assign o_amp_valid   = (state_q == ST_SEND);
  assign o_amp_idx     = {addr_q, lane_q};
  assign o_amp_last    = (state_q == ST_SEND) && (addr_q == last_addr_q) && (lane_q == last_lane_q);

endmodule

// File: tb/tb_qea_state_reader.sv
// Bench for qea_state_reader: two instances (read latency 1 and 3) share stimulus,
// each backed by a small state-RAM model; a scoreboard queue holds expected beats.
module tb_qea_state_reader;
  import qea_pkg::*;

  localparam int PW  = 2;
  localparam int PN  = 4;
  localparam int SDW = 64;
  localparam int SAW = 16;
  localparam int MQW = 6;
  localparam int IW  = SAW + PW;
  localparam logic [PN*SDW-1:0] JUNK = {16{16'hdead}};

  typedef struct packed {
    logic [SDW-1:0] data;
    logic [IW-1:0]  idx;
    logic           last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start;
  logic [MQW-1:0] qbit;
  logic           ready;
  int             sel;
  int             mem_mode;
  int             errors = 0;
  int             checks = 0;
  beat_t          sb_q[$];

  logic a_busy, a_done, a_err, a_ena, a_wea, a_valid, a_last;
  logic [SAW-1:0]    a_addr;
  logic [PN*SDW-1:0] a_dout, a_p1;
  logic [SDW-1:0]    a_data;
  logic [IW-1:0]     a_idx;
  logic b_busy, b_done, b_err, b_ena, b_wea, b_valid, b_last;
  logic [SAW-1:0]    b_addr;
  logic [PN*SDW-1:0] b_dout, b_p1, b_p2, b_p3;
  logic [SDW-1:0]    b_data;
  logic [IW-1:0]     b_idx;

  qea_state_reader #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .i_start(start), .i_qbit_num(qbit),
    .o_busy(a_busy), .o_done(a_done), .o_err(a_err),
    .o_state_ena(a_ena), .o_state_wea(a_wea), .o_state_addra(a_addr),
    .i_state_dout(a_dout), .o_amp_valid(a_valid), .i_amp_ready(ready),
    .o_amp_data(a_data), .o_amp_idx(a_idx), .o_amp_last(a_last)
  );

  qea_state_reader #(.RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .i_start(start), .i_qbit_num(qbit),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
    .o_state_ena(b_ena), .o_state_wea(b_wea), .o_state_addra(b_addr),
    .i_state_dout(b_dout), .o_amp_valid(b_valid), .i_amp_ready(ready),
    .o_amp_data(b_data), .o_amp_idx(b_idx), .o_amp_last(b_last)
  );

  // RAM contents: mode 0 = single 1.0 amplitude at lane 0 of word 0; mode 1 = lane p of word a is {a,p}
  function automatic logic [PN*SDW-1:0] word_of(input logic [SAW-1:0] addr, input int mode);
    logic [PN*SDW-1:0] w;
    amp_t a;
    w = '0;
    for (int p = 0; p < PN; p++) begin
      if (mode == 0) begin
        a.re = (addr == '0 && p == 0) ? 32'h4000_0000 : 32'h0;
        a.im = 32'h0;
      end else begin
        a.re = 32'(addr);
        a.im = 32'(p);
      end
      w[(PN-p)*SDW-1 -: SDW] = a;
    end
    return w;
  endfunction

  function automatic logic [SDW-1:0] exp_amp(input int idx, input int mode);
    if (mode == 0) return (idx == 0) ? 64'h4000_0000_0000_0000 : 64'h0;
    return {32'(idx >> 2), 32'(idx & 3)};
  endfunction

  always @(posedge clk) begin
    a_p1 <= a_ena ? word_of(a_addr, mem_mode) : JUNK;
    b_p1 <= b_ena ? word_of(b_addr, mem_mode) : JUNK;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign a_dout = a_p1;
  assign b_dout = b_p3;

  logic m_busy, m_done, m_err, m_ena, m_valid, m_last;
  logic [SAW-1:0] m_addr;
  logic [SDW-1:0] m_data;
  logic [IW-1:0]  m_idx;
  always_comb begin
    m_busy  = (sel == 1) ? b_busy  : a_busy;
    m_done  = (sel == 1) ? b_done  : a_done;
    m_err   = (sel == 1) ? b_err   : a_err;
    m_ena   = (sel == 1) ? b_ena   : a_ena;
    m_valid = (sel == 1) ? b_valid : a_valid;
    m_last  = (sel == 1) ? b_last  : a_last;
    m_addr  = (sel == 1) ? b_addr  : a_addr;
    m_data  = (sel == 1) ? b_data  : a_data;
    m_idx   = (sel == 1) ? b_idx   : a_idx;
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    ready = 1'b1;
    start = 1'b0;
    while ((a_busy || b_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_busy || b_busy) begin
      errors++;
      $display("FAIL %s idle: busy_a=%0b busy_b=%0b still high, expected both idle", name, a_busy, b_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  // Full sweep on the selected instance with scoreboard, handshake and timing checks.
  task automatic run_sweep(input string name, input int sel_i, input int q, input int mode,
                           input int toggle, input int lat, input int mid_start);
    int n, words, cyc, beats, enas, dones, errs, first_valid, first_ena, last_hs, done_cyc;
    bit held;
    beat_t hold, got, exp;
    sel = sel_i;
    mem_mode = mode;
    n = 1 << q;
    words = (q <= PW) ? 1 : (1 << (q - PW));
    for (int i = 0; i < n; i++) sb_q.push_back('{data: exp_amp(i, mode), idx: IW'(i), last: (i == n - 1)});
    cyc = 0; beats = 0; enas = 0; dones = 0; errs = 0;
    first_valid = -1; first_ena = -1; last_hs = -1; done_cyc = -1; held = 0; hold = '0;
    @(posedge clk); #1;
    start = 1'b1; qbit = MQW'(q); ready = 1'b1;
    while (dones == 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid_start);
      qbit  = (cyc == mid_start) ? '0 : MQW'(q);
      ready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      got = '{data: m_data, idx: m_idx, last: m_last};
      if (held) begin
        checks++;
        if (!m_valid || got !== hold) begin
          errors++;
          $display("FAIL %s hold c%0d: valid=%0b beat=%h, expected valid=1 beat=%h", name, cyc, m_valid, got, hold);
        end
      end
      if (m_ena) begin
        if (first_ena < 0) first_ena = cyc;
        checks++;
        if (m_addr !== SAW'(enas)) begin
          errors++;
          $display("FAIL %s read_addr #%0d: got %0d, expected %0d", name, enas, m_addr, enas);
        end
        enas++;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: got idx=%0d, expected no beat", name, m_idx);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL %s beat%0d: got data=%h idx=%0d last=%0b, expected data=%h idx=%0d last=%0b",
                     name, beats, got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
          end
        end
        beats++;
        last_hs = cyc;
      end
      held = m_valid && !ready;
      hold = got;
      if (m_err) errs++;
      if (m_done) begin
        dones++;
        done_cyc = cyc;
        checks++;
        if (m_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_at_done: got %0b, expected 0", name, m_busy);
        end
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s done_seen: got %0d pulses, expected 1", name, dones); end
    checks++;
    if (first_ena != 1) begin errors++; $display("FAIL %s ena_latency: got cycle %0d, expected 1", name, first_ena); end
    checks++;
    if (first_valid != 2 + lat) begin errors++; $display("FAIL %s valid_latency: got cycle %0d, expected %0d", name, first_valid, 2 + lat); end
    checks++;
    if (beats != n || sb_q.size() != 0) begin errors++; $display("FAIL %s beat_count: got %0d, expected %0d", name, beats, n); end
    checks++;
    if (enas != words) begin errors++; $display("FAIL %s read_count: got %0d, expected %0d", name, enas, words); end
    checks++;
    if (done_cyc != last_hs + 1) begin errors++; $display("FAIL %s done_timing: got cycle %0d, expected %0d", name, done_cyc, last_hs + 1); end
    checks++;
    if (errs != 0) begin errors++; $display("FAIL %s err_pulse: got %0d, expected 0", name, errs); end
    sb_q.delete();
    wait_idle(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_err, a_ena, a_wea, a_addr, a_valid, a_data, a_idx, a_last,
         b_busy, b_done, b_err, b_ena, b_wea, b_addr, b_valid, b_data, b_idx, b_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b ena=%0b valid=%0b addr=%0d, expected all 0", a_busy, a_ena, a_valid, a_addr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_range_err();
    int bad;
    for (int q = 19; q <= 20; q++) begin
      @(posedge clk); #1;
      start = 1'b1; qbit = MQW'(q);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_err, a_busy, b_err, b_busy} !== 4'b1010) begin
        errors++;
        $display("FAIL range_err q=%0d: got err/busy a=%0b%0b b=%0b%0b, expected 10 10", q, a_err, a_busy, b_err, b_busy);
      end
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (a_err || a_busy || a_ena || b_err || b_busy || b_ena) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL range_quiet q=%0d: got %0d active cycles, expected 0", q, bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, dones;
    sel = 0;
    mem_mode = 1;
    @(posedge clk); #1;
    start = 1'b1; qbit = MQW'(4); ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(a_valid && a_idx == IW'(5)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(a_valid && a_idx == IW'(5))) begin
      errors++;
      $display("FAIL rst_mid_reach: got idx=%0d valid=%0b, expected idx 5 valid", a_idx, a_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_err, a_ena, a_wea, a_addr, a_valid, a_data, a_idx, a_last} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got busy=%0b valid=%0b idx=%0d addr=%0d done=%0b, expected all 0",
               a_busy, a_valid, a_idx, a_addr, a_done);
    end
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_done || a_busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: got %0d active cycles, expected 0", dones);
    end
    run_sweep("rst_restart", 0, 4, 1, 0, 1, 0);
  endtask

  initial begin
    start = 1'b0; qbit = '0; ready = 1'b1; sel = 0; mem_mode = 0; rst = 1'b1;
    test_reset();
    run_sweep("q3_basic", 0, 3, 0, 0, 1, 0);
    run_sweep("q4_toggle", 0, 4, 1, 1, 1, 0);
    run_sweep("q1_small", 0, 1, 1, 0, 1, 0);
    run_sweep("q0_single", 0, 0, 1, 0, 1, 0);
    test_range_err();
    test_reset_mid();
    run_sweep("rl3_q3", 1, 3, 1, 0, 3, 7);
    run_sweep("rl3_q4_toggle", 1, 4, 1, 1, 3, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
